// File: rtl/axis_burst_pkg.sv
// Shared types for the line burst writer: read FSM states, segment FIFO entry layout and clogb2.
package axis_burst_pkg;

  localparam int unsigned AXI_LEN_W = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } rd_state_e;

  // One entry per burst: AXI len (beats-1) and whether the burst closes a line.
  typedef struct packed {
    logic [AXI_LEN_W-1:0] len;
    logic                 line_end;
  } seg_t;

  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) res++;
    return (res == 0) ? 32'd1 : res;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count; DEPTH need not be a power of two.
module axis_sync_fifo
  import axis_burst_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CntW = clogb2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = clogb2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/axis_line_burst_writer.sv
// AXIS line sink that cuts each line into bursts of at most BURST_LEN words for an AXI4 writer.
// Optional stream pattern checker enabled by defining AXIS_PATTERN_CHECK_EN.
module axis_line_burst_writer
  import axis_burst_pkg::*;
#(
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_ADDR_WIDTH         = 32,
  parameter int unsigned WORDS_PER_LINE       = 320,
  parameter int unsigned LINES_PER_FRAME      = 1024,
  parameter int unsigned BURST_LEN            = 16,
  parameter int unsigned FIFO_DEPTH           = 64,
  parameter logic [31:0] FRAME_BASE           = 32'h1000_0000,
  parameter logic [31:0] LINE_STRIDE          = 32'h0000_1000,
  parameter logic [31:0] FRAME_STRIDE         = 32'h0040_0000,
  parameter int unsigned FRAME_BUFS           = 3
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESET,
  input  logic                              S_AXIS_TVALID,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  output logic                              REQ_VALID,
  input  logic                              REQ_READY,
  output logic [C_ADDR_WIDTH-1:0]           REQ_ADDR,
  output logic [AXI_LEN_W-1:0]              REQ_LEN,
  output logic                              WD_VALID,
  input  logic                              WD_READY,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   WD_DATA,
  output logic                              WD_LAST,
  output logic                              FRAME_DONE,
  output logic                              ERR_LINE_LEN,
  output logic                              ERR_PATTERN
);

  localparam int unsigned W        = C_S_AXIS_TDATA_WIDTH;
  localparam int unsigned AW       = C_ADDR_WIDTH;
  localparam int unsigned Bytes    = W / 8;
  localparam int unsigned SegDepth = FIFO_DEPTH / BURST_LEN + 2;
  localparam int unsigned WidxW    = clogb2(WORDS_PER_LINE);
  localparam int unsigned SegCntW  = clogb2(BURST_LEN);
  localparam int unsigned LineW    = clogb2(LINES_PER_FRAME);
  localparam int unsigned BufW     = clogb2(FRAME_BUFS);
  localparam int unsigned OffW     = clogb2(WORDS_PER_LINE + 1);
  localparam int unsigned DataCntW = clogb2(FIFO_DEPTH + 1);
  localparam int unsigned SegCntFW = clogb2(SegDepth + 1);

  // Write side
  logic               out_en_q;
  logic [WidxW-1:0]   word_idx_q;
  logic [SegCntW-1:0] seg_cnt_q;
  logic               err_line_len_q;
  logic               beat, at_line_end, line_close, cut;
  logic               data_full, data_empty, seg_full, seg_empty;
  logic [W-1:0]       data_rd;
  seg_t               seg_wr, seg_rd;
  logic               unused_tstrb;
  logic [DataCntW-1:0] unused_data_cnt;
  logic [SegCntFW-1:0] unused_seg_cnt;

  // Read side
  rd_state_e            state_q, state_d;
  logic [AXI_LEN_W-1:0] len_q, beat_cnt_q;
  logic                 line_end_q;
  logic [OffW-1:0]      off_q;
  logic [LineW-1:0]     line_q;
  logic [BufW-1:0]      buf_q;
  logic                 frame_done_q;
  logic                 seg_pop, wd_fire, wd_last_beat;
  logic [AW-1:0]        req_addr;

  assign unused_tstrb = ^S_AXIS_TSTRB;

  // out_en_q keeps TREADY low while reset is asserted even though the FIFOs read empty.
  assign S_AXIS_TREADY = out_en_q && !data_full && !seg_full;
  assign beat          = S_AXIS_TVALID && S_AXIS_TREADY;
  assign at_line_end   = (word_idx_q == WidxW'(WORDS_PER_LINE - 1));
  assign line_close    = beat && (S_AXIS_TLAST || at_line_end);
  assign cut           = beat && ((seg_cnt_q == SegCntW'(BURST_LEN - 1)) || line_close);
  assign seg_wr        = '{len: AXI_LEN_W'(seg_cnt_q), line_end: line_close};

  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      out_en_q       <= 1'b0;
      word_idx_q     <= '0;
      seg_cnt_q      <= '0;
      err_line_len_q <= 1'b0;
    end else begin
      out_en_q <= 1'b1;
      if (beat) begin
        word_idx_q <= line_close ? '0 : word_idx_q + WidxW'(1);
        seg_cnt_q  <= cut ? '0 : seg_cnt_q + SegCntW'(1);
        if (S_AXIS_TLAST != at_line_end) begin
          err_line_len_q <= 1'b1;
        end
      end
    end
  end

  assign ERR_LINE_LEN = err_line_len_q;

`ifdef AXIS_PATTERN_CHECK_EN
  logic [LineW-1:0] wr_line_q;
  logic [3:0]       wr_frame_q;
  logic             err_pattern_q;
  logic [31:0]      pat_tag;
  logic [W-1:0]     pat_exp;

  assign pat_tag = {wr_frame_q, 12'(wr_line_q), 16'h0000};
  assign pat_exp = W'(word_idx_q) + W'(pat_tag);

  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      wr_line_q     <= '0;
      wr_frame_q    <= '0;
      err_pattern_q <= 1'b0;
    end else begin
      if (line_close) begin
        if (wr_line_q == LineW'(LINES_PER_FRAME - 1)) begin
          wr_line_q  <= '0;
          wr_frame_q <= wr_frame_q + 4'd1;
        end else begin
          wr_line_q <= wr_line_q + LineW'(1);
        end
      end
      if (beat && (S_AXIS_TDATA != pat_exp)) begin
        err_pattern_q <= 1'b1;
      end
    end
  end

  assign ERR_PATTERN = err_pattern_q;
`else
  assign ERR_PATTERN = 1'b0;
`endif

  axis_sync_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_data_fifo (
    .clk_i   (S_AXIS_ACLK),
    .rst_i   (S_AXIS_ARESET),
    .push_i  (beat),
    .wdata_i (S_AXIS_TDATA),
    .pop_i   (wd_fire),
    .rdata_o (data_rd),
    .full_o  (data_full),
    .empty_o (data_empty),
    .count_o (unused_data_cnt)
  );

  axis_sync_fifo #(
    .WIDTH ($bits(seg_t)),
    .DEPTH (SegDepth)
  ) u_seg_fifo (
    .clk_i   (S_AXIS_ACLK),
    .rst_i   (S_AXIS_ARESET),
    .push_i  (cut),
    .wdata_i (seg_wr),
    .pop_i   (seg_pop),
    .rdata_o (seg_rd),
    .full_o  (seg_full),
    .empty_o (seg_empty),
    .count_o (unused_seg_cnt)
  );

  assign seg_pop      = (state_q == StIdle) && !seg_empty;
  assign wd_fire      = WD_VALID && WD_READY;
  assign wd_last_beat = wd_fire && (beat_cnt_q == len_q);

  assign req_addr = AW'(FRAME_BASE)
                  + AW'(buf_q) * AW'(FRAME_STRIDE)
                  + AW'(line_q) * AW'(LINE_STRIDE)
                  + AW'(off_q) * AW'(Bytes);

  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!seg_empty) state_d = StAddr;
      StAddr:  if (REQ_READY) state_d = StData;
      StData:  if (wd_last_beat) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    REQ_VALID = 1'b0;
    REQ_ADDR  = '0;
    REQ_LEN   = '0;
    WD_VALID  = 1'b0;
    WD_DATA   = '0;
    WD_LAST   = 1'b0;
    unique case (state_q)
      StAddr: begin
        REQ_VALID = 1'b1;
        REQ_ADDR  = req_addr;
        REQ_LEN   = len_q;
      end
      StData: begin
        WD_VALID = !data_empty;
        if (!data_empty) begin
          WD_DATA = data_rd;
          WD_LAST = (beat_cnt_q == len_q);
        end
      end
      default: ;
    endcase
  end

  // Burst bookkeeping: addresses advance only once the whole burst has been handed over.
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      len_q        <= '0;
      line_end_q   <= 1'b0;
      beat_cnt_q   <= '0;
      off_q        <= '0;
      line_q       <= '0;
      buf_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (seg_pop) begin
        len_q      <= seg_rd.len;
        line_end_q <= seg_rd.line_end;
        beat_cnt_q <= '0;
      end
      if (wd_fire) begin
        beat_cnt_q <= beat_cnt_q + AXI_LEN_W'(1);
      end
      if (wd_last_beat) begin
        if (line_end_q) begin
          off_q <= '0;
          if (line_q == LineW'(LINES_PER_FRAME - 1)) begin
            line_q       <= '0;
            buf_q        <= (buf_q == BufW'(FRAME_BUFS - 1)) ? '0 : buf_q + BufW'(1);
            frame_done_q <= 1'b1;
          end else begin
            line_q <= line_q + LineW'(1);
          end
        end else begin
          off_q <= off_q + OffW'(len_q) + OffW'(1);
        end
      end
    end
  end

  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_axis_line_burst_writer.sv
// Directed bench for axis_line_burst_writer (4 lines per frame to keep frame tests short).
module tb_axis_line_burst_writer;

  logic        clk;
  logic        rst;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb;
  logic        s_tlast;
  logic        s_tready;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic        wd_valid;
  logic        wd_ready;
  logic [31:0] wd_data;
  logic        wd_last;
  logic        frame_done;
  logic        err_line_len;
  logic        err_pattern;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int fd_cnt = 0;

  logic [31:0] mon_addr[$];
  logic [7:0]  mon_len[$];
  logic [31:0] mon_data[$];
  logic        mon_last[$];
  logic [31:0] exp_data[$];

  axis_line_burst_writer #(
    .LINES_PER_FRAME (4)
  ) dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESET (rst),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TSTRB  (s_tstrb),
    .S_AXIS_TLAST  (s_tlast),
    .S_AXIS_TREADY (s_tready),
    .REQ_VALID     (req_valid),
    .REQ_READY     (req_ready),
    .REQ_ADDR      (req_addr),
    .REQ_LEN       (req_len),
    .WD_VALID      (wd_valid),
    .WD_READY      (wd_ready),
    .WD_DATA       (wd_data),
    .WD_LAST       (wd_last),
    .FRAME_DONE    (frame_done),
    .ERR_LINE_LEN  (err_line_len),
    .ERR_PATTERN   (err_pattern)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshakes sampled 1 time unit before each rising edge.
  always @(negedge clk) begin
    #4;
    if (!rst) begin
      if (req_valid && req_ready) begin
        mon_addr.push_back(req_addr);
        mon_len.push_back(req_len);
      end
      if (wd_valid && wd_ready) begin
        mon_data.push_back(wd_data);
        mon_last.push_back(wd_last);
      end
      if (s_tvalid && s_tready) acc_cnt++;
      if (frame_done) fd_cnt++;
    end
  end

  task automatic clear_mon();
    mon_addr.delete();
    mon_len.delete();
    mon_data.delete();
    mon_last.delete();
    exp_data.delete();
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    int guard;
    guard = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    #4;
    while (!s_tready && guard < 3000) begin
      @(negedge clk);
      #4;
      guard++;
    end
    if (!s_tready) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: tready got 0 want 1");
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_line(input int frame, input int line, input int nwords, input int corrupt,
                           input bit with_last);
    logic [3:0]  f4;
    logic [11:0] l12;
    logic [31:0] d;
    f4  = frame[3:0];
    l12 = line[11:0];
    for (int i = 0; i < nwords; i++) begin
      d = 32'(i) + {f4, l12, 16'h0000};
      if (i == corrupt) d = d ^ 32'h00a5_0000;
      exp_data.push_back(d);
      send_beat(d, with_last && (i == nwords - 1));
    end
  endtask

  task automatic wait_drain(input int n);
    int guard;
    guard = 0;
    while (mon_data.size() < n && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (mon_data.size() < n) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: beats got %0d want %0d", mon_data.size(), n);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b want 0", s_tready); end
    checks++;
    if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
    checks++;
    if (wd_valid !== 1'b0) begin errors++; $display("FAIL reset_wd_valid: got %b want 0", wd_valid); end
    checks++;
    if (req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr: got %h want 0", req_addr); end
    checks++;
    if ({frame_done, err_line_len, err_pattern} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000", {frame_done, err_line_len, err_pattern});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (s_tready !== 1'b1) begin errors++; $display("FAIL post_reset_tready: got %b want 1", s_tready); end
  endtask

  // Shared burst-layout check for a line: lens, addresses, data order and WD_LAST positions.
  task automatic check_line(input string tag, input logic [31:0] base, input int nwords);
    int nreq;
    logic [7:0] exp_len;
    nreq = (nwords + 15) / 16;
    checks++;
    if (mon_addr.size() != nreq) begin
      errors++;
      $display("FAIL %s_req_count: got %0d want %0d", tag, mon_addr.size(), nreq);
    end
    for (int k = 0; k < mon_addr.size() && k < nreq; k++) begin
      exp_len = (k == nreq - 1) ? 8'(nwords - 16 * k - 1) : 8'd15;
      checks++;
      if (mon_addr[k] !== base + 32'(k) * 32'h40 || mon_len[k] !== exp_len) begin
        errors++;
        $display("FAIL %s_req%0d: got addr %h len %0d want addr %h len %0d", tag, k, mon_addr[k],
                 mon_len[k], base + 32'(k) * 32'h40, exp_len);
      end
    end
    checks++;
    if (mon_data.size() != nwords) begin
      errors++;
      $display("FAIL %s_beat_count: got %0d want %0d", tag, mon_data.size(), nwords);
    end
    for (int i = 0; i < mon_data.size() && i < nwords; i++) begin
      checks++;
      if (mon_data[i] !== exp_data[i] ||
          mon_last[i] !== ((i % 16 == 15) || (i == nwords - 1))) begin
        errors++;
        $display("FAIL %s_beat%0d: got data %h last %b want data %h last %b", tag, i, mon_data[i],
                 mon_last[i], exp_data[i], (i % 16 == 15) || (i == nwords - 1));
      end
    end
  endtask

  task automatic test_full_line();
    clear_mon();
    send_line(0, 0, 320, -1, 1'b1);
    wait_drain(320);
    check_line("full_line", 32'h1000_0000, 320);
    checks++;
    if (err_line_len !== 1'b0) begin errors++; $display("FAIL full_line_err_len: got %b want 0", err_line_len); end
    checks++;
    if (err_pattern !== 1'b0) begin errors++; $display("FAIL full_line_err_pat: got %b want 0", err_pattern); end
  endtask

  task automatic test_short_line();
    clear_mon();
    send_line(0, 1, 100, -1, 1'b1);
    wait_drain(100);
    check_line("short_line", 32'h1000_1000, 100);
    checks++;
    if (err_line_len !== 1'b1) begin errors++; $display("FAIL short_line_err_len: got %b want 1", err_line_len); end
  endtask

  task automatic test_backpressure();
    int base;
    logic exp_pat;
`ifdef AXIS_PATTERN_CHECK_EN
    exp_pat = 1'b1;
`else
    exp_pat = 1'b0;
`endif
    clear_mon();
    wd_ready = 1'b0;
    base = acc_cnt;
    fork
      send_line(0, 2, 320, 5, 1'b1);
      begin
        repeat (200) @(negedge clk);
        #1;
        checks++;
        if (acc_cnt - base != 64) begin
          errors++;
          $display("FAIL stall_accepted: got %0d want 64", acc_cnt - base);
        end
        checks++;
        if (s_tready !== 1'b0) begin errors++; $display("FAIL stall_tready: got %b want 0", s_tready); end
        wd_ready = 1'b1;
      end
    join
    wait_drain(320);
    check_line("stall_line", 32'h1000_2000, 320);
    checks++;
    if (err_pattern !== exp_pat) begin
      errors++;
      $display("FAIL pattern_err: got %b want %b", err_pattern, exp_pat);
    end
  endtask

  task automatic test_frames();
    int fd0;
    logic [31:0] exp_addr;
    fd0 = fd_cnt;
    clear_mon();
    send_line(0, 3, 320, -1, 1'b1);
    wait_drain(320);
    checks++;
    if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL frame0_done: got %0d want 1", fd_cnt - fd0); end
    checks++;
    if (mon_addr.size() < 1 || mon_addr[0] !== 32'h1000_3000) begin
      errors++;
      $display("FAIL frame0_last_line_addr: got %h want 10003000",
               (mon_addr.size() > 0) ? mon_addr[0] : 32'hx);
    end
    for (int f = 1; f <= 3; f++) begin
      for (int l = 0; l < ((f == 3) ? 1 : 4); l++) begin
        clear_mon();
        send_line(f, l, 320, -1, 1'b1);
        wait_drain(320);
        exp_addr = 32'h1000_0000 + 32'(f % 3) * 32'h0040_0000 + 32'(l) * 32'h1000;
        checks++;
        if (mon_addr.size() < 1 || mon_addr[0] !== exp_addr) begin
          errors++;
          $display("FAIL frame%0d_line%0d_addr: got %h want %h", f, l,
                   (mon_addr.size() > 0) ? mon_addr[0] : 32'hx, exp_addr);
        end
      end
    end
    checks++;
    if (fd_cnt - fd0 != 3) begin errors++; $display("FAIL frame_done_total: got %0d want 3", fd_cnt - fd0); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    wd_ready = 1'b0;
    send_line(0, 1, 20, -1, 1'b0);
    @(negedge clk);
    checks++;
    if (wd_valid !== 1'b1) begin errors++; $display("FAIL mid_burst_setup: wd_valid got %b want 1", wd_valid); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({s_tready, req_valid, wd_valid, wd_last, frame_done, err_line_len, err_pattern} !== 7'b0) begin
      errors++;
      $display("FAIL mid_reset_ctrl: got %b want 0000000",
               {s_tready, req_valid, wd_valid, wd_last, frame_done, err_line_len, err_pattern});
    end
    checks++;
    if (req_addr !== 32'h0 || req_len !== 8'h0 || wd_data !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_bus: got addr %h len %h data %h want 0", req_addr, req_len, wd_data);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wd_ready = 1'b1;
    @(negedge clk);
    clear_mon();
    send_line(0, 0, 320, -1, 1'b1);
    wait_drain(320);
    check_line("restart", 32'h1000_0000, 320);
    checks++;
    if (err_line_len !== 1'b0) begin errors++; $display("FAIL restart_err_len: got %b want 0", err_line_len); end
  endtask

  initial begin
    rst       = 1'b1;
    s_tvalid  = 1'b0;
    s_tdata   = '0;
    s_tstrb   = 4'hf;
    s_tlast   = 1'b0;
    req_ready = 1'b1;
    wd_ready  = 1'b1;
    test_reset();
    test_full_line();
    test_short_line();
    test_backpressure();
    test_frames();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
